// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, runs the imem request/ack handshake and
// loads the IF/ID register, absorbing stalls, redirects and HALT.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_INC   = 16'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc_inc,
  output logic        if_id_valid,
  output logic [10:0] extend_field,
  output logic        halted
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    BUF   = 2'd1,
    DROP  = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [15:0] NOP_INSTR = 16'h0800;

  state_t      state_q;
  logic [15:0] pc_q;
  logic [15:0] pend_pc_q;
  logic [15:0] buf_instr_q;
  logic [15:0] buf_pc_inc_q;
  logic [15:0] if_id_instr_q;
  logic [15:0] if_id_pc_inc_q;
  logic        if_id_valid_q;
  logic [15:0] pc_inc_d;

  // 16-bit add wraps 16'hFFFE -> 16'h0000 naturally.
  assign pc_inc_d = pc_q + PC_INC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= FETCH;
      pc_q           <= RESET_PC;
      pend_pc_q      <= 16'h0000;
      buf_instr_q    <= 16'h0000;
      buf_pc_inc_q   <= 16'h0000;
      if_id_instr_q  <= NOP_INSTR;
      if_id_pc_inc_q <= 16'h0000;
      if_id_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (redirect) begin
            if_id_valid_q <= 1'b0;
            if (imem_ack) begin
              pc_q <= redirect_pc;
            end else begin
              pend_pc_q <= redirect_pc;
              state_q   <= DROP;
            end
          end else if (imem_ack && !stall) begin
            if_id_instr_q  <= imem_rdata;
            if_id_pc_inc_q <= pc_inc_d;
            if_id_valid_q  <= 1'b1;
            pc_q           <= pc_inc_d;
            state_q        <= (imem_rdata[15:11] == 5'b00000) ? HALT : FETCH;
          end else if (imem_ack) begin
            // ID is stalled: park the word so it is neither lost nor refetched.
            buf_instr_q  <= imem_rdata;
            buf_pc_inc_q <= pc_inc_d;
            pc_q         <= pc_inc_d;
            state_q      <= BUF;
          end else if (!stall) begin
            if_id_valid_q <= 1'b0;
          end
        end
        BUF: begin
          if (redirect) begin
            if_id_valid_q <= 1'b0;
            pc_q          <= redirect_pc;
            state_q       <= FETCH;
          end else if (!stall) begin
            if_id_instr_q  <= buf_instr_q;
            if_id_pc_inc_q <= buf_pc_inc_q;
            if_id_valid_q  <= 1'b1;
            state_q        <= (buf_instr_q[15:11] == 5'b00000) ? HALT : FETCH;
          end
        end
        DROP: begin
          // The in-flight request at the old pc must finish before retargeting.
          if_id_valid_q <= 1'b0;
          if (imem_ack) begin
            pc_q    <= redirect ? redirect_pc : pend_pc_q;
            state_q <= FETCH;
          end else if (redirect) begin
            pend_pc_q <= redirect_pc;
          end
        end
        HALT: begin
          if (redirect) begin
            if_id_valid_q <= 1'b0;
            pc_q          <= redirect_pc;
            state_q       <= FETCH;
          end else if (!stall) begin
            if_id_valid_q <= 1'b0;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  assign imem_req     = (state_q == FETCH) || (state_q == DROP);
  assign imem_addr    = pc_q;
  assign if_id_instr  = if_id_instr_q;
  assign if_id_pc_inc = if_id_pc_inc_q;
  assign if_id_valid  = if_id_valid_q;
  assign extend_field = if_id_instr_q[10:0];
  assign halted       = (state_q == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage with hand-computed expectations.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc_inc;
  logic        if_id_valid;
  logic [10:0] extend_field;
  logic        halted;

  int n_tests;
  int n_fail;

  fetch_stage #(.RESET_PC(16'h0000), .PC_INC(16'd2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .if_id_instr  (if_id_instr),
    .if_id_pc_inc (if_id_pc_inc),
    .if_id_valid  (if_id_valid),
    .extend_field (extend_field),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic cyc(input logic ack, input logic [15:0] rdata, input logic stl,
                     input logic redir, input logic [15:0] rpc);
    imem_ack    = ack;
    imem_rdata  = rdata;
    stall       = stl;
    redirect    = redir;
    redirect_pc = rpc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic v, input logic [15:0] instr,
                          input logic [15:0] pci);
    chk({tag, "_valid"}, {31'd0, if_id_valid}, {31'd0, v});
    chk({tag, "_instr"}, {16'd0, if_id_instr}, {16'd0, instr});
    chk({tag, "_pcinc"}, {16'd0, if_id_pc_inc}, {16'd0, pci});
  endtask

  task automatic chk_req(input string tag, input logic req, input logic [15:0] addr);
    chk({tag, "_req"},  {31'd0, imem_req},  {31'd0, req});
    chk({tag, "_addr"}, {16'd0, imem_addr}, {16'd0, addr});
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    imem_ack = 1'b0; imem_rdata = 16'h0;
    #12;
    chk_ifid("rst", 1'b0, 16'h0800, 16'h0000);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_addr", {16'd0, imem_addr}, 32'h0000);
    @(posedge clk); #1 rst_n = 1'b1;
    chk_req("t1_start", 1'b1, 16'h0000);

    // 1: zero-wait acks
    cyc(1'b1, 16'h0800, 1'b0, 1'b0, 16'h0);
    chk_ifid("t1_a", 1'b1, 16'h0800, 16'h0002);
    chk_req("t1_a", 1'b1, 16'h0002);
    chk("t1_a_ext", {21'd0, extend_field}, 32'h000);
    cyc(1'b1, 16'h0A05, 1'b0, 1'b0, 16'h0);
    chk_ifid("t1_b", 1'b1, 16'h0A05, 16'h0004);
    chk("t1_b_ext", {21'd0, extend_field}, 32'h205);
    chk_req("t1_b", 1'b1, 16'h0004);
    cyc(1'b1, 16'h0FFF, 1'b0, 1'b0, 16'h0);
    chk_ifid("t1_c", 1'b1, 16'h0FFF, 16'h0006);
    chk("t1_c_ext", {21'd0, extend_field}, 32'h7FF);

    // 2: two wait states
    cyc(1'b0, 16'hDEAD, 1'b0, 1'b0, 16'h0);
    chk("t2_w1_valid", {31'd0, if_id_valid}, 32'd0);
    chk_req("t2_w1", 1'b1, 16'h0006);
    cyc(1'b0, 16'hDEAD, 1'b0, 1'b0, 16'h0);
    chk("t2_w2_valid", {31'd0, if_id_valid}, 32'd0);
    chk_req("t2_w2", 1'b1, 16'h0006);
    cyc(1'b1, 16'h1234, 1'b0, 1'b0, 16'h0);
    chk_ifid("t2_ack", 1'b1, 16'h1234, 16'h0008);
    chk_req("t2_ack", 1'b1, 16'h0008);

    // 3: stall coincident with ack of 4123 at pc 8
    cyc(1'b1, 16'h4123, 1'b1, 1'b0, 16'h0);
    chk_ifid("t3_s1", 1'b1, 16'h1234, 16'h0008);
    chk_req("t3_s1", 1'b0, 16'h000A);
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    chk_ifid("t3_s2", 1'b1, 16'h1234, 16'h0008);
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    chk_ifid("t3_s3", 1'b1, 16'h1234, 16'h0008);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    chk_ifid("t3_rel", 1'b1, 16'h4123, 16'h000A);
    chk_req("t3_rel", 1'b1, 16'h000A);

    // 4: redirect while waiting -> DROP, late ack discarded
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 16'h0040);
    chk("t4_r_valid", {31'd0, if_id_valid}, 32'd0);
    chk_req("t4_r", 1'b1, 16'h000A);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    chk("t4_w_valid", {31'd0, if_id_valid}, 32'd0);
    chk_req("t4_w", 1'b1, 16'h000A);
    cyc(1'b1, 16'h5555, 1'b0, 1'b0, 16'h0);
    chk_ifid("t4_ack", 1'b0, 16'h4123, 16'h000A);
    chk_req("t4_ack", 1'b1, 16'h0040);

    // 5: HALT then redirect out
    cyc(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0);
    chk_ifid("t5_h", 1'b1, 16'h0000, 16'h0042);
    chk("t5_h_halted", {31'd0, halted}, 32'd1);
    chk("t5_h_req", {31'd0, imem_req}, 32'd0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    chk("t5_drop_valid", {31'd0, if_id_valid}, 32'd0);
    chk("t5_still_halted", {31'd0, halted}, 32'd1);
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 16'h0020);
    chk("t5_r_halted", {31'd0, halted}, 32'd0);
    chk_req("t5_r", 1'b1, 16'h0020);

    // 6: wrap at FFFE, then async reset mid-wait
    cyc(1'b1, 16'h7777, 1'b0, 1'b1, 16'hFFFE);
    chk_req("t6_jmp", 1'b1, 16'hFFFE);
    chk("t6_jmp_valid", {31'd0, if_id_valid}, 32'd0);
    cyc(1'b1, 16'h2222, 1'b0, 1'b0, 16'h0);
    chk_ifid("t6_wrap", 1'b1, 16'h2222, 16'h0000);
    chk_req("t6_wrap", 1'b1, 16'h0000);
    cyc(1'b1, 16'h3333, 1'b0, 1'b0, 16'h0);
    chk_ifid("t6_next", 1'b1, 16'h3333, 16'h0002);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    chk_req("t6_wait", 1'b1, 16'h0002);
    #2 rst_n = 1'b0;
    #1;
    chk_ifid("t6_rst", 1'b0, 16'h0800, 16'h0000);
    chk("t6_rst_addr", {16'd0, imem_addr}, 32'h0000);
    chk("t6_rst_halted", {31'd0, halted}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    chk_req("t6_restart", 1'b1, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
